rat_io_responder: RTL

Peripheral-side I/O responder for the RAT MCU port bus. It decodes `PORT_ID`/`IO_STRB` writes into output registers and drives `IN_PORT` for MCU reads. It also hosts an interval timer and a button edge detector, and raises `INT_CU` until software acknowledges the interrupt. It sits between the RAT_MCU and the board I/O (switches, button, LEDs, 7-segment value).

---
 rtl/rat_io_responder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rat_io_responder.sv
// Peripheral-side I/O responder for the RAT MCU port bus: output registers,
// readback mux, interval timer, button edge detector and interrupt control.
module rat_io_responder #(
  parameter logic [7:0] SW_ID    = 8'h20,
  parameter logic [7:0] LED_ID   = 8'h40,
  parameter logic [7:0] SSEG_ID  = 8'h81,
  parameter logic [7:0] TMR_ID   = 8'h30,
  parameter logic [7:0] IRQ_ID   = 8'h31,
  parameter logic [7:0] MASK_ID  = 8'h32,
  parameter int         PRESCALE = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [7:0] IN_PORT,
  output logic       INT_CU,
  input  logic [7:0] SWITCHES,
  input  logic       BTN,
  output logic [7:0] LEDS,
  output logic [7:0] SSEG_VAL
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [7:0]    led_q;
  logic [7:0]    sseg_q;
  logic [7:0]    reload_q;
  logic [7:0]    count_q;
  logic [PW-1:0] prescale_q;
  logic [1:0]    pending_q;
  logic [1:0]    mask_q;
  logic          btn_meta_q;
  logic          btn_sync_q;
  logic          btn_dly_q;

  logic          wr_led;
  logic          wr_sseg;
  logic          wr_tmr;
  logic          wr_irq;
  logic          wr_mask;
  logic          tick;
  logic          timer_expire;
  logic          btn_rise;
  logic [1:0]    pending_set;
  logic [1:0]    pending_clr;

  // Write decode: a strobe to an unmapped ID matches nothing and is dropped.
  assign wr_led  = IO_STRB && (PORT_ID == LED_ID);
  assign wr_sseg = IO_STRB && (PORT_ID == SSEG_ID);
  assign wr_tmr  = IO_STRB && (PORT_ID == TMR_ID);
  assign wr_irq  = IO_STRB && (PORT_ID == IRQ_ID);
  assign wr_mask = IO_STRB && (PORT_ID == MASK_ID);

  assign tick         = (prescale_q == PRE_LAST);
  // A reload write restarts the period, so it suppresses any expiry that edge.
  assign timer_expire = !wr_tmr && (reload_q != 8'd0) && tick && (count_q == 8'd1);
  assign btn_rise     = btn_sync_q && !btn_dly_q;

  assign pending_set = {btn_rise, timer_expire};
  assign pending_clr = wr_irq ? OUT_PORT[1:0] : 2'b00;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      led_q  <= 8'h00;
      sseg_q <= 8'h00;
      mask_q <= 2'b11;
    end else begin
      if (wr_led)  led_q  <= OUT_PORT;
      if (wr_sseg) sseg_q <= OUT_PORT;
      if (wr_mask) mask_q <= OUT_PORT[1:0];
    end
  end

  // Interval timer: prescaler divides CLK, count runs reload..1 then reloads.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      reload_q   <= 8'h00;
      count_q    <= 8'h00;
      prescale_q <= '0;
    end else if (wr_tmr) begin
      reload_q   <= OUT_PORT;
      count_q    <= OUT_PORT;
      prescale_q <= '0;
    end else if (reload_q != 8'd0) begin
      if (tick) begin
        prescale_q <= '0;
        count_q    <= (count_q == 8'd1) ? reload_q : count_q - 8'd1;
      end else begin
        prescale_q <= prescale_q + 1'b1;
      end
    end
  end

  // Two-flop synchronizer for the asynchronous button plus one delay flop.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      btn_dly_q  <= 1'b0;
    end else begin
      btn_meta_q <= BTN;
      btn_sync_q <= btn_meta_q;
      btn_dly_q  <= btn_sync_q;
    end
  end

  // Set is applied after clear so a coincident event is never lost.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pending_q <= 2'b00;
    end else begin
      pending_q <= (pending_q & ~pending_clr) | pending_set;
    end
  end

  assign INT_CU   = |(pending_q & mask_q);
  assign LEDS     = led_q;
  assign SSEG_VAL = sseg_q;

  // NOTE: IN_PORT gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    IN_PORT = 8'h00;
    case (PORT_ID)
      SW_ID:   IN_PORT = SWITCHES;
      LED_ID:  IN_PORT = led_q;
      SSEG_ID: IN_PORT = sseg_q;
      TMR_ID:  IN_PORT = count_q;
      IRQ_ID:  IN_PORT = {6'b000000, pending_q};
      MASK_ID: IN_PORT = {6'b000000, mask_q};
      default: IN_PORT = 8'h00;
    endcase
  end

endmodule
